// File: rtl/lbp_pkg.sv
// Shared constants for the LBP raster scan: image defaults, FSM encodings,
// 3x3 window byte indices and the neighbour read-order tables.
package lbp_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;

  localparam int FILL_READS  = 9;
  localparam int SLIDE_READS = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SLIDE = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Window bytes in raster order, k = 3*dy + dx
  localparam logic [3:0] K_TL = 4'd0;
  localparam logic [3:0] K_TC = 4'd1;
  localparam logic [3:0] K_TR = 4'd2;
  localparam logic [3:0] K_ML = 4'd3;
  localparam logic [3:0] K_MC = 4'd4;
  localparam logic [3:0] K_MR = 4'd5;
  localparam logic [3:0] K_BL = 4'd6;
  localparam logic [3:0] K_BC = 4'd7;
  localparam logic [3:0] K_BR = 4'd8;

  // dy/dx are biased by +1: 0 means -1, 1 means 0, 2 means +1
  typedef struct packed {
    logic [1:0] dy;
    logic [1:0] dx;
    logic [3:0] k;
  } rd_ofs_t;

  // FILL walks the window column by column, top to bottom
  function automatic rd_ofs_t fill_ofs(input logic [3:0] idx);
    rd_ofs_t o;
    case (idx)
      4'd0:    o = '{dy: 2'd0, dx: 2'd0, k: K_TL};
      4'd1:    o = '{dy: 2'd1, dx: 2'd0, k: K_ML};
      4'd2:    o = '{dy: 2'd2, dx: 2'd0, k: K_BL};
      4'd3:    o = '{dy: 2'd0, dx: 2'd1, k: K_TC};
      4'd4:    o = '{dy: 2'd1, dx: 2'd1, k: K_MC};
      4'd5:    o = '{dy: 2'd2, dx: 2'd1, k: K_BC};
      4'd6:    o = '{dy: 2'd0, dx: 2'd2, k: K_TR};
      4'd7:    o = '{dy: 2'd1, dx: 2'd2, k: K_MR};
      default: o = '{dy: 2'd2, dx: 2'd2, k: K_BR};
    endcase
    return o;
  endfunction

  // SLIDE only fetches the new right-hand column
  function automatic rd_ofs_t slide_ofs(input logic [3:0] idx);
    rd_ofs_t o;
    case (idx)
      4'd0:    o = '{dy: 2'd0, dx: 2'd2, k: K_TR};
      4'd1:    o = '{dy: 2'd1, dx: 2'd2, k: K_MR};
      default: o = '{dy: 2'd2, dx: 2'd2, k: K_BR};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lbp_window_buf.sv
// 3x3 pixel window register file: one byte written per cycle, or a one-column
// left shift when the scan steps right. Output is registered, no backpressure.
module lbp_window_buf
  import lbp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_en_i,
  input  logic [3:0]  load_idx_i,
  input  logic [7:0]  load_dat_i,
  input  logic        shift_en_i,
  output logic [71:0] win_o
);

  logic [7:0] pix_q [9];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) begin
        pix_q[k] <= '0;
      end
    end else begin
      if (shift_en_i) begin
        pix_q[K_TL] <= pix_q[K_TC];
        pix_q[K_TC] <= pix_q[K_TR];
        pix_q[K_ML] <= pix_q[K_MC];
        pix_q[K_MC] <= pix_q[K_MR];
        pix_q[K_BL] <= pix_q[K_BC];
        pix_q[K_BC] <= pix_q[K_BR];
      end
      if (load_en_i) begin
        pix_q[load_idx_i] <= load_dat_i;
      end
    end
  end

  always_comb begin
    win_o = '0;
    for (int k = 0; k < 9; k++) begin
      win_o[8*k +: 8] = pix_q[k];
    end
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan 3x3 window fetcher: 11 cycles per row-start window, 5 per slide.
// Reads stall while gray_ready is low; a window is held until win_ready accepts it.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [ADDR_W-1:0] win_addr,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] POS_FIRST = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IMG_H - 2);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0]    iss_q, iss_d;
  logic          pend_q, pend_d;
  logic [3:0]    pidx_q, pidx_d;

  logic [3:0]    n_reads;
  rd_ofs_t       ofs;
  logic          issuing;
  logic          rd_fire;
  logic          win_fire;
  logic          last_win;
  logic          shift_en;
  logic [CW-1:0] rd_row;
  logic [CW-1:0] rd_col;

  always_comb begin
    n_reads = (state_q == S_FILL) ? 4'(FILL_READS) : 4'(SLIDE_READS);
    ofs     = (state_q == S_FILL) ? fill_ofs(iss_q) : slide_ofs(iss_q);
    issuing = ((state_q == S_FILL) || (state_q == S_SLIDE)) && (iss_q < n_reads);
    rd_fire = issuing && gray_ready;
    // Centres are interior, so the biased offsets never wrap
    rd_row  = row_q + CW'(ofs.dy) - POS_FIRST;
    rd_col  = col_q + CW'(ofs.dx) - POS_FIRST;
  end

  assign gray_req  = rd_fire;
  assign gray_addr = issuing ? ADDR_W'({rd_row, rd_col}) : '0;
  assign win_valid = (state_q == S_EMIT);
  assign win_fire  = win_valid && win_ready;
  assign win_addr  = win_valid ? ADDR_W'({row_q, col_q}) : '0;
  assign finish    = (state_q == S_DONE);
  assign last_win  = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    iss_d    = iss_q;
    pend_d   = rd_fire;
    pidx_d   = rd_fire ? ofs.k : pidx_q;
    shift_en = 1'b0;
    if (rd_fire) begin
      iss_d = iss_q + 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (gray_ready) begin
          state_d = S_FILL;
          iss_d   = '0;
        end
      end
      S_FILL, S_SLIDE: begin
        // All reads issued; the last one is being captured this cycle
        if (iss_q == n_reads) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (win_fire) begin
          iss_d = '0;
          if (last_win) begin
            state_d = S_DONE;
          end else if (col_q == COL_LAST) begin
            col_d   = POS_FIRST;
            row_d   = row_q + POS_FIRST;
            state_d = S_FILL;
          end else begin
            col_d    = col_q + POS_FIRST;
            shift_en = 1'b1;
            state_d  = S_SLIDE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= POS_FIRST;
      col_q   <= POS_FIRST;
      iss_q   <= '0;
      pend_q  <= 1'b0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      iss_q   <= iss_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
    end
  end

  lbp_window_buf u_win_buf (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_en_i  (pend_q),
    .load_idx_i (pidx_q),
    .load_dat_i (gray_data),
    .shift_en_i (shift_en),
    .win_o      (win_data)
  );

endmodule

// File: doc/lbp_scan_ctrl.md
# lbp_scan_ctrl

Raster-scan controller for the LBP datapath. It walks every interior pixel of the gray image and fetches each 3x3 neighbourhood over the single gray-memory read port. Adjacent windows share two columns, so only the new column is re-read. Each complete window is presented, with its output address, to the LBP compute engine over a valid/ready handshake. It sits between the gray image memory and the LBP compute/write-back stage and owns the `finish` signal.

## Interface
- `IMG_W`, 128, image width in pixels; power of 2.
- `IMG_H`, 128, image height in pixels.
- `ADDR_W`, 14, memory address width; equals log2(IMG_W*IMG_H).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `gray_ready`  in  1  gray memory can accept a read this cycle.
- `gray_req`  out  1  read request; a read is accepted when `gray_req && gray_ready` at a rising edge.
- `gray_addr`  out  ADDR_W  read address, {row, col}.
- `gray_data`  in  8  read data, valid exactly one cycle after the accepting edge.
- `win_valid`  out  1  window and address are valid.
- `win_ready`  in  1  engine accepts the window.
- `win_data`  out  72  3x3 window; byte k = `win_data[8k+7:8k]`, k = 3*dy+dx, raster order: k=0 top-left, k=4 centre, k=8 bottom-right.
- `win_addr`  out  ADDR_W  centre pixel address {row, col}; used as the LBP output address.
- `finish`  out  1  all windows delivered; sticky until reset.

## Operation
- Scan covers centres row 1..IMG_H-2 and col 1..IMG_W-2, row-major. Total windows = (IMG_W-2)*(IMG_H-2), which is 15876 at default sizes.
- States:
  - IDLE: wait for `gray_ready`, then go to FILL.
  - FILL: 9 reads in column-major order: (r-1,c-1),(r,c-1),(r+1,c-1),(r-1,c),…,(r+1,c+1). Then go to EMIT.
  - SLIDE: shift the window one column left (k0←k1, k1←k2, k3←k4 …). Then issue 3 reads (r-1,c+1),(r,c+1),(r+1,c+1) into k2, k5, k8. Then go to EMIT.
  - EMIT: hold `win_valid`. On `win_valid && win_ready`:
    - last window → DONE;
    - col == IMG_W-2 → col=1, row+1, FILL;
    - else col+1, SLIDE.
  - DONE: `finish`=1; no further requests. Stay in DONE until reset.
- Address arithmetic: row and col are each log2(IMG_W) bits wide. Neighbour addresses are formed as {row±1, col±1}; they never wrap because centres are interior.
- A read issues only when `gray_ready`=1. If `gray_ready` is low, `gray_req` stays low and the read sequence pauses. An already-accepted read is still captured on the following cycle.
- The window is never presented partially filled. `win_valid` rises only after the last of the state's reads has been captured.

## Timing
- Reset values: `gray_req`=0, `gray_addr`=0, `win_valid`=0, `win_data`=0, `win_addr`=0, `finish`=0; state IDLE, row=1, col=1.
- With `gray_ready` held high:
  - FILL = 9 issue cycles plus 1 capture cycle. `win_valid` is high on the 11th cycle after FILL entry.
  - SLIDE = 3 issue cycles plus 1 capture cycle. `win_valid` is high on the 5th cycle after SLIDE entry.
- EMIT lasts at least 1 cycle. A window accepted in its first EMIT cycle gives 5 cycles per pixel in SLIDE, and 11 cycles at a row start.
- While `win_valid`=1 and `win_ready`=0, `win_data` and `win_addr` are held stable.
- `win_ready` high before `win_valid` has no effect.
- `finish` rises the cycle after the last window is accepted.
- Reset asserted mid-operation: all outputs go to their reset values immediately. The scan restarts from (1,1) after reset is released.

## Structure
- Package `lbp_pkg`:
  - `IMG_W`/`IMG_H` defaults;
  - state enum {IDLE, FILL, SLIDE, EMIT, DONE};
  - window index constants K_TL=0 … K_BR=8;
  - read-offset table for FILL order.
- Sub-module `lbp_window_buf`: 9x8-bit register file with `load_en`/`load_idx` (write `gray_data` to byte k) and `shift_en` (column shift left). Output is the 72-bit window.
- `lbp_scan_ctrl` keeps the FSM, row/col counters, read-issue counter, and pending-capture flag.

## Test plan
- Memory model returns `gray_data` = address[7:0], with `gray_ready`=1 and `win_ready`=1. Required response:
  - `gray_addr` sequence is 0,128,256,1,129,257,2,130,258.
  - First window bytes k0..k8 = 0x00,0x01,0x02,0x80,0x81,0x82,0x00,0x01,0x02.
  - `win_addr`=129.
- Second window: only addresses 3,131,259 are read; `win_addr`=130; k2=0x03, k5=0x83, k8=0x03.
- Hold `win_ready`=0 for 5 cycles during EMIT → `win_valid` held, `win_data`/`win_addr` unchanged, no `gray_req`. Acceptance occurs on the cycle `win_ready` rises.
- Drop `gray_ready` for 3 cycles after the 4th FILL read → no `gray_req` during the gap; the read sequence resumes at the 5th address; the window is still correct.
- Row wrap: after `win_addr`=254 (row 1, col 126), the next reads are 128,256,384 (FILL for row 2); next `win_addr`=257.
- Full run: exactly 15876 accepted windows; `finish`=1 the cycle after the last window (`win_addr`=16254); `finish` stays high with no further requests. Assert reset mid-run → outputs return to 0 immediately; the scan restarts at `gray_addr`=0.
